// File: rtl/voice_frame_player.sv
// voice_frame_player: ping-pong frame buffer that replays processed frames one sample per tick.
// Optional build macro VOICE_PLAY_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module voice_frame_player #(
    parameter int FRAME_LEN = 256,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_tick,
    output logic [DW-1:0] o_sample,
    output logic          o_sample_valid,
    output logic          o_underrun,
    output logic          o_playing
`ifdef VOICE_PLAY_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   o_underrun_cnt
`endif
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    logic [DW-1:0] r_buf [2][FRAME_LEN];
    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW-1:0] r_wr_idx;
    logic [AW-1:0] r_rd_idx;
    state_t        r_state;

    logic          w_accept;
    logic          w_rd_hit;
    logic [1:0]    w_full_set;
    logic [1:0]    w_full_clr;

    assign o_ready    = rst & ~r_full[r_wr_bank];
    assign w_accept   = i_valid & o_ready;
    assign w_rd_hit   = (r_state == S_PLAY) & i_tick & r_full[r_rd_bank];
    assign w_full_set = (w_accept && r_wr_idx == LAST) ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = (w_rd_hit && r_rd_idx == LAST) ? (2'b01 << r_rd_bank) : 2'b00;

    // Sample storage; contents survive reset, only the flags make them visible.
    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_wr_bank][r_wr_idx] <= i_data;
    end

    // Write pointer: a frame boundary is purely a count of accepted samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_accept) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            if (r_wr_idx == LAST) r_wr_bank <= ~r_wr_bank;
        end
    end

    // Full flags: writer sets, reader clears; they never target the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) r_full <= 2'b00;
        else      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end

    // Read FSM with registered outputs. An empty tick in PLAY still emits a zero sample;
    // that same tick drops back to IDLE once nothing is buffered or being written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_rd_bank      <= 1'b0;
            r_rd_idx       <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_underrun     <= 1'b0;
            o_playing      <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_underrun     <= 1'b0;
            if (r_state == S_IDLE) begin
                o_underrun <= i_tick;
                if (r_full[r_rd_bank]) begin
                    r_state   <= S_PLAY;
                    o_playing <= 1'b1;
                end
            end else if (i_tick) begin
                o_sample_valid <= 1'b1;
                if (r_full[r_rd_bank]) begin
                    o_sample <= r_buf[r_rd_bank][r_rd_idx];
                    r_rd_idx <= r_rd_idx + 1'b1;
                    if (r_rd_idx == LAST) r_rd_bank <= ~r_rd_bank;
                end else begin
                    o_sample   <= '0;
                    o_underrun <= 1'b1;
                    if (r_full == 2'b00 && r_wr_idx == '0) begin
                        r_state   <= S_IDLE;
                        o_playing <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef VOICE_PLAY_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)                                    o_underrun_cnt <= '0;
        else if (o_underrun && o_underrun_cnt != 16'hFFFF) o_underrun_cnt <= o_underrun_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_voice_frame_player.sv
// tb_voice_frame_player: scoreboard bench for the ping-pong voice frame player.
module tb_voice_frame_player;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_tick = 1'b0;
    logic [15:0] o_sample;
    logic        o_sample_valid;
    logic        o_underrun;
    logic        o_playing;
`ifdef VOICE_PLAY_UNDERRUN_CNT_EN
    logic [15:0] o_underrun_cnt;
`endif

    typedef struct packed {logic [15:0] s; logic v; logic u;} exp_t;
    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic tick_at_edge = 1'b0;
    logic held_done;

    voice_frame_player dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_tick(i_tick), .o_sample(o_sample), .o_sample_valid(o_sample_valid),
        .o_underrun(o_underrun), .o_playing(o_playing)
`ifdef VOICE_PLAY_UNDERRUN_CNT_EN
        , .o_underrun_cnt(o_underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_at_edge <= i_tick;

    // Monitor: every output pulse must match the next queued expectation, one clock after a tick.
    always @(negedge clk) begin
        if (rst && (o_sample_valid || o_underrun)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: sample=%0d valid=%0b underrun=%0b with empty queue",
                         o_sample, o_sample_valid, o_underrun);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (o_sample !== e.s || o_sample_valid !== e.v || o_underrun !== e.u || !tick_at_edge) begin
                    n_err++;
                    $display("FAIL output: got sample=%0d valid=%0b underrun=%0b tick_prev=%0b, expected sample=%0d valid=%0b underrun=%0b tick_prev=1",
                             o_sample, o_sample_valid, o_underrun, tick_at_edge, e.s, e.v, e.u);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] v);
        int n = 0;
        i_data  = v;
        i_valid = 1'b1;
        while (!o_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("wr_timeout", 32'(o_ready), 1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic tk(input logic [15:0] s, input logic v, input logic u, input int gap);
        i_tick = 1'b1;
        q.push_back(exp_t'{s, v, u});
        @(negedge clk);
        i_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        i_tick = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", 32'(o_ready), 0);
        repeat (2) @(negedge clk);
        chk("reset_sample", 32'(o_sample), 0);
        chk("reset_flags", {29'd0, o_sample_valid, o_underrun, o_playing}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(o_ready), 1);
    endtask

    initial begin
        do_reset();
        // Ticks in IDLE: underrun pulses only.
        for (int i = 0; i < 3; i++) tk(16'd0, 1'b0, 1'b1, 2);
        repeat (3) @(negedge clk);
`ifdef VOICE_PLAY_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(o_underrun_cnt), 3);
`endif
        chk("idle_not_playing", 32'(o_playing), 0);

        // One frame, then a tick every 4 clocks.
        for (int i = 0; i < 256; i++) wr(16'(i));
        repeat (2) @(negedge clk);
        chk("t1_playing", 32'(o_playing), 1);
        for (int i = 0; i < 256; i++) tk(16'(i), 1'b1, 1'b0, 3);
        repeat (2) @(negedge clk);
        chk("t1_still_playing", 32'(o_playing), 1);

        // Empty tick: zero sample with underrun, then back to IDLE.
        tk(16'd0, 1'b1, 1'b1, 2);
        chk("t3_idle", 32'(o_playing), 0);

        // Two frames with no ticks fill both banks; the next sample waits for a freed bank.
        for (int i = 0; i < 512; i++) wr(16'(1000 + i));
        chk("t2_ready_low", 32'(o_ready), 0);
        held_done = 1'b0;
        fork
            begin
                wr(16'd2000);
                held_done = 1'b1;
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    tk(16'(1000 + i), 1'b1, 1'b0, 1);
                    if (i == 254) chk("t2_held", {30'd0, held_done, o_ready}, 0);
                end
            end
        join
        chk("t2_released", 32'(held_done), 1);
        for (int i = 0; i < 256; i++) tk(16'(1256 + i), 1'b1, 1'b0, 1);
        repeat (3) @(negedge clk);

        // Reset after 100 written and 50 played.
        do_reset();
        for (int i = 0; i < 256; i++) wr(16'(3000 + i));
        repeat (2) @(negedge clk);
        fork
            for (int i = 0; i < 50; i++) tk(16'(3000 + i), 1'b1, 1'b0, 1);
            for (int i = 0; i < 100; i++) wr(16'(4000 + i));
        join
        repeat (3) @(negedge clk);
        do_reset();
        for (int i = 0; i < 256; i++) wr(16'(5000 + i));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) tk(16'(5000 + i), 1'b1, 1'b0, 1);
        tk(16'd0, 1'b1, 1'b1, 2);
        chk("t5_idle", 32'(o_playing), 0);

        // Continuous write and tick every clock: output is input delayed by one frame.
        fork
            for (int i = 0; i < 768; i++) wr(16'(6000 + i));
            begin
                int n = 0;
                while (!o_playing && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("t4_playing", 32'(o_playing), 1);
                for (int i = 0; i < 768; i++) tk(16'(6000 + i), 1'b1, 1'b0, 0);
            end
        join
        tk(16'd0, 1'b1, 1'b1, 2);
        chk("t4_idle", 32'(o_playing), 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
